bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Round-robin owner selection for the shared tri-state data bus.
//  - Drives the enable (c) inputs of the tristate_buffer instances hanging off the bus.
//  - At most one buffer is enabled at any time.
//  - A mandatory all-off turnaround gap separates successive owners, so drivers never overlap.
//  - Sits directly upstream of the buffers; requesters are the register/ALU stages that want the bus.
// PARAMETERS
//  N_REQ     4  number of requesters/buffers (>=2)
//  MAX_HOLD  8  max consecutive cycles one owner may hold the bus (>=1)
//  TURN_CYC  1  all-off turnaround cycles between owners (>=1)
// PORTS
//  clk       in   1                 rising-edge clock
//  rst_n     in   1                 async active-low reset
//  req       in   N_REQ             per-requester bus request, level, sampled on clk
//  drv_en    out  N_REQ             one-hot-or-zero buffer enables (to tristate c)
//  grant_id  out  clog2(N_REQ)      index of current owner; valid only while bus_busy=1
//  bus_busy  out  1                 1 while some drv_en bit is high
//  turn      out  1                 1 during turnaround cycles
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (rst_n=0, asynchronous, immediate):
//  - drv_en=0, grant_id=0, bus_busy=0, turn=0, state=IDLE, hold_cnt=0, turn_cnt=0.
//  - last_owner=N_REQ-1, so req[0] has top priority first.
//  - Reset mid-grant releases the bus in the same instant (bus floats).
//  All outputs are registered; drv_en comes straight from flops (glitch-free).
//  FSM states:
//  - IDLE: drv_en=0. If |req at edge -> GRANT to winner W; drv_en[W]=1 from that edge.
//  - GRANT: drv_en[owner]=1, hold_cnt counts granted cycles from 1.
//    - Exit to TURN at the edge where req[owner]==0 OR hold_cnt==MAX_HOLD.
//    - Otherwise stay; hold_cnt+1.
//    - On exit: last_owner<=owner, drv_en<=0, turn<=1.
//  - TURN: drv_en=0, turn=1 for exactly TURN_CYC cycles (turn_cnt).
//    - On final TURN cycle: if |req -> GRANT to new winner, hold_cnt<=1; else -> IDLE.
//  Arbitration:
//  - Winner = first set bit of req scanning upward (mod N_REQ) from last_owner+1.
//  - An owner cut off by MAX_HOLD that keeps requesting gets lowest priority next round.
//  Latency:
//  - req rising in IDLE -> drv_en high 1 cycle later.
//  - Owner drop -> drv_en low 1 cycle later.
//  - Next owner drv_en high TURN_CYC cycles after that.
//  Boundary cases:
//  - req[owner] drop coincident with hold_cnt==MAX_HOLD: single exit to TURN.
//  - MAX_HOLD=1: each grant lasts exactly 1 cycle.
//  - Requests arriving during TURN: considered only at the last TURN cycle.
//  - Lone continuous requester: MAX_HOLD on, TURN_CYC off, repeating.
//  Invariants (assert):
//  - $onehot0(drv_en) always.
//  - bus_busy==|drv_en.
//  - Owner change always separated by >=TURN_CYC zero cycles.
//  - turn && bus_busy never both 1.
// TESTING (defaults N_REQ=4, MAX_HOLD=8, TURN_CYC=1)
//  1 Reset: rst_n=0 with req=4'hF mid-grant -> drv_en=0 immediately; after release, first grant to req[0] (drv_en=4'b0001).
//  2 Single req: req=4'b0100 at cycle 0, held; drop at cycle 3 ->
//    - drv_en=4'b0100 cycles 1-3, 4'b0000 + turn=1 cycle 4, IDLE cycle 5.
//  3 Timeout: req=4'b0010 held 20 cycles ->
//    - drv_en high 8 cycles, 1 zero cycle, high 8, zero 1, ...; grant_id=1.
//  4 Round robin: req=4'b1111 held ->
//    - owners 0,1,2,3,0 each 8 cycles, each followed by a 1-cycle gap.
//  5 Contention check: random req for 10k cycles, TURN_CYC=2 ->
//    - $onehot0 never violated; every owner change has >=2 zero cycles.
//  6 Coincident drop + timeout at hold_cnt=8, req[2] rising same cycle ->
//    - exactly one TURN cycle, then drv_en=4'b0100.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus: one-hot-or-zero buffer
// enables, a bounded hold time per owner and an all-off turnaround gap between owners.
module bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         drv_en,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     bus_busy,
    output logic                     turn,
    output logic [1:0]               dbg_state
);
    localparam int IDW = $clog2(N_REQ);
    localparam int HW  = $clog2(MAX_HOLD + 1);
    localparam int TW  = $clog2(TURN_CYC + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [N_REQ-1:0] r_drv_en;
    logic [IDW-1:0]   r_grant_id;
    logic [IDW-1:0]   r_last_owner;
    logic             r_bus_busy;
    logic             r_turn;
    logic [HW-1:0]    r_hold_cnt;
    logic [TW-1:0]    r_turn_cnt;

    logic             w_found;
    logic [IDW-1:0]   w_winner;
    logic [N_REQ-1:0] w_winner_oh;
    logic             w_release;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % N_REQ;
        return IDW'(s);
    endfunction

    // Scan upward from the previous owner so it is the last one considered.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_found && req[next_idx(r_last_owner, k)]) begin
                w_found  = 1'b1;
                w_winner = next_idx(r_last_owner, k);
            end
        end
    end

    assign w_winner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
    assign w_release   = !req[r_grant_id] || (r_hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_drv_en     <= '0;
            r_grant_id   <= '0;
            r_last_owner <= IDW'(N_REQ - 1);
            r_bus_busy   <= 1'b0;
            r_turn       <= 1'b0;
            r_hold_cnt   <= '0;
            r_turn_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_GRANT;
                        r_drv_en   <= w_winner_oh;
                        r_grant_id <= w_winner;
                        r_bus_busy <= 1'b1;
                        r_hold_cnt <= HW'(1);
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_state      <= S_TURN;
                        r_last_owner <= r_grant_id;
                        r_drv_en     <= '0;
                        r_bus_busy   <= 1'b0;
                        r_turn       <= 1'b1;
                        r_turn_cnt   <= TW'(1);
                        r_hold_cnt   <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                S_TURN: begin
                    // Requests are only looked at on the last turnaround cycle.
                    if (r_turn_cnt == TURN_LAST) begin
                        r_turn     <= 1'b0;
                        r_turn_cnt <= '0;
                        if (w_found) begin
                            r_state    <= S_GRANT;
                            r_drv_en   <= w_winner_oh;
                            r_grant_id <= w_winner;
                            r_bus_busy <= 1'b1;
                            r_hold_cnt <= HW'(1);
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_turn_cnt <= r_turn_cnt + TW'(1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_drv_en   <= '0;
                    r_bus_busy <= 1'b0;
                    r_turn     <= 1'b0;
                end
            endcase
        end
    end

    assign drv_en    = r_drv_en;
    assign grant_id  = r_grant_id;
    assign bus_busy  = r_bus_busy;
    assign turn      = r_turn;
    assign dbg_state = r_state;

    a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_drv_en));
    a_busy:    assert property (@(posedge clk) disable iff (!rst_n) r_bus_busy == |r_drv_en);
    a_no_both: assert property (@(posedge clk) disable iff (!rst_n) !(r_turn && r_bus_busy));

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed per-cycle expectations through a scoreboard queue,
// plus a random contention run on TURN_CYC=2 and MAX_HOLD=1 instances.
module tb_bus_arbiter;
    logic       clk;
    logic       rst_n;
    logic [3:0] req;

    logic [3:0] drv_en;
    logic [1:0] grant_id;
    logic       bus_busy;
    logic       turn;
    logic [1:0] dbg_state;

    logic [3:0] drv2;
    logic [1:0] gid2;
    logic       bus2;
    logic       turn2;
    logic [1:0] st2;

    logic [3:0] drv3;
    logic [1:0] gid3;
    logic       bus3;
    logic       turn3;
    logic [1:0] st3;

    int         n_checks;
    int         n_fail;
    logic       rnd_on;
    logic [7:0] exp_q[$];

    bus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .TURN_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .drv_en(drv_en), .grant_id(grant_id),
        .bus_busy(bus_busy), .turn(turn), .dbg_state(dbg_state)
    );

    bus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .TURN_CYC(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .drv_en(drv2), .grant_id(gid2),
        .bus_busy(bus2), .turn(turn2), .dbg_state(st2)
    );

    bus_arbiter #(.N_REQ(4), .MAX_HOLD(1), .TURN_CYC(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req), .drv_en(drv3), .grant_id(gid3),
        .bus_busy(bus3), .turn(turn3), .dbg_state(st3)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Expected entry layout: {turn, bus_busy, grant_id[1:0], drv_en[3:0]}
    function automatic logic [7:0] pack_exp(input logic [3:0] d, input logic t);
        logic [1:0] id;
        id = d[3] ? 2'd3 : d[2] ? 2'd2 : d[1] ? 2'd1 : 2'd0;
        return {t, |d, id, d};
    endfunction

    task automatic push_exp(input logic [3:0] d, input logic t);
        exp_q.push_back(pack_exp(d, t));
    endtask

    // Apply req for the next edge; d/t are the outputs expected after that edge.
    task automatic drive(input logic [3:0] r, input logic [3:0] d, input logic t);
        @(negedge clk);
        req = r;
        push_exp(d, t);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_drv_en"}, 32'(drv_en), 32'h0);
        check({tag, "_bus_busy"}, 32'(bus_busy), 32'h0);
        check({tag, "_turn"}, 32'(turn), 32'h0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = 4'h0;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor / scoreboard
    logic [3:0] prev2;
    logic [3:0] prev3;
    int         zrun2;
    bit         seen2;
    logic [7:0] e;
    logic [7:0] a;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {turn, bus_busy, grant_id, drv_en};
            if (!e[6]) a[5:4] = 2'b00;
            check("directed", 32'(a), 32'(e));
        end
        if (!rnd_on) begin
            seen2 = 1'b0;
        end else begin
            check("dut2_onehot0", 32'($onehot0(drv2)), 32'h1);
            check("dut2_busy_eq", 32'(bus2), 32'(|drv2));
            check("dut2_turn_and_busy", 32'(turn2 & bus2), 32'h0);
            if (drv2 != 4'h0 && seen2) begin
                if (prev2 != 4'h0) check("dut2_direct_switch", 32'(drv2), 32'(prev2));
                else check("dut2_gap_ge2", 32'(zrun2 >= 2), 32'h1);
            end
            check("dut3_onehot0", 32'($onehot0(drv3)), 32'h1);
            check("dut3_hold1", 32'((drv3 != 4'h0) && (prev3 != 4'h0)), 32'h0);
        end
        if (drv2 != 4'h0) begin
            seen2 = 1'b1;
            zrun2 = 0;
        end else begin
            zrun2++;
        end
        prev2 = drv2;
        prev3 = drv3;
    end

    // Stimulus
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rnd_on   = 1'b0;
        zrun2    = 0;
        prev2    = 4'h0;
        prev3    = 4'h0;
        rst_n    = 1'b0;
        req      = 4'h0;
        repeat (2) @(negedge clk);
        check_idle_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-grant, then first grant goes to req[0]
        drive(4'hF, 4'b0001, 1'b0);
        drive(4'hF, 4'b0001, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(4'b0001, 1'b0);
        drive(4'h0, 4'b0000, 1'b1);
        drive(4'h0, 4'b0000, 1'b0);

        // Single requester, dropped after 3 grant cycles
        repeat (3) drive(4'b0100, 4'b0100, 1'b0);
        drive(4'b0000, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0);

        // Lone continuous requester: 8 on, 1 off, repeating
        repeat (2) begin
            repeat (8) drive(4'b0010, 4'b0010, 1'b0);
            drive(4'b0010, 4'b0000, 1'b1);
        end
        repeat (2) drive(4'b0010, 4'b0010, 1'b0);
        drive(4'b0000, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0);

        // Round robin with everyone requesting, from a fresh reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] oh;
            oh = 4'b0001 << i;
            repeat (8) drive(4'hF, oh, 1'b0);
            drive(4'hF, 4'b0000, 1'b1);
        end
        repeat (8) drive(4'hF, 4'b0001, 1'b0);
        drive(4'h0, 4'b0000, 1'b1);
        drive(4'h0, 4'b0000, 1'b0);

        // Owner drop coincident with timeout while req[2] rises
        repeat (8) drive(4'b0001, 4'b0001, 1'b0);
        drive(4'b0100, 4'b0000, 1'b1);
        drive(4'b0100, 4'b0100, 1'b0);
        drive(4'b0100, 4'b0100, 1'b0);
        drive(4'b0000, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0);

        // Priority from last owner 2: req[3] beats req[1]; req[1] taken after turnaround
        drive(4'b1010, 4'b1000, 1'b0);
        drive(4'b0010, 4'b0000, 1'b1);
        drive(4'b0010, 4'b0010, 1'b0);
        drive(4'b0000, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0);

        repeat (2) @(posedge clk);

        // Random contention on the TURN_CYC=2 and MAX_HOLD=1 instances
        @(negedge clk);
        rnd_on = 1'b1;
        repeat (10000) begin
            @(negedge clk);
            req = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        rnd_on = 1'b0;
        req    = 4'h0;
        repeat (2) @(posedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
